// File: rtl/if_id_stage_if.sv
// Fetch/decode boundary bus: environment-side inputs and IF/ID register outputs.
// The stage itself connects through the slave modport.
interface if_id_stage_if #(
  parameter int STALL_CNT_W = 16
);
  logic                   hit;
  logic [31:0]            instruction;
  logic                   branch_taken;
  logic [31:0]            branch_target;
  logic                   ID_EX_MEM_Read;
  logic [4:0]             ID_EX_RT;
  logic [31:0]            pc;
  logic [31:0]            instruction_output;
  logic [31:0]            nextPC_output;
  logic                   hit_output;
  logic                   id_bubble;
  logic [STALL_CNT_W-1:0] stall_count;

  modport master (
    output hit, instruction, branch_taken, branch_target, ID_EX_MEM_Read, ID_EX_RT,
    input  pc, instruction_output, nextPC_output, hit_output, id_bubble, stall_count
  );

  modport slave (
    input  hit, instruction, branch_taken, branch_target, ID_EX_MEM_Read, ID_EX_RT,
    output pc, instruction_output, nextPC_output, hit_output, id_bubble, stall_count
  );
endinterface

// File: rtl/if_id_stage.sv
// MIPS fetch front end: PC, IF/ID register, load-use hazard detection,
// branch flush, cache-miss bubbles and a saturating stall-cycle counter.
module if_id_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          PC_STEP     = 4,
  parameter int          STALL_CNT_W = 16
) (
  input logic         clk,
  input logic         reset,
  if_id_stage_if.slave bus
);

  logic [31:0]            pc_q, pc_d;
  logic [31:0]            instr_q, instr_d;
  logic [31:0]            next_pc_q, next_pc_d;
  logic                   hit_q, hit_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  logic        hazard;
  logic        stall_sat;
  logic [31:0] pc_plus;

  // Load-use: the load in ID_EX writes a register the held instruction reads.
  assign hazard = hit_q & bus.ID_EX_MEM_Read & (bus.ID_EX_RT != 5'd0) &
                  ((bus.ID_EX_RT == instr_q[25:21]) | (bus.ID_EX_RT == instr_q[20:16]));

  assign stall_sat = &stall_q;
  assign pc_plus   = pc_q + 32'(PC_STEP);

  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    next_pc_d = next_pc_q;
    hit_d     = hit_q;
    stall_d   = stall_q;
    if (bus.branch_taken) begin
      pc_d      = bus.branch_target;
      instr_d   = '0;
      next_pc_d = '0;
      hit_d     = 1'b0;
    end else if (hazard) begin
      if (!stall_sat) stall_d = stall_q + 1'b1;
    end else if (!bus.hit) begin
      instr_d   = '0;
      next_pc_d = '0;
      hit_d     = 1'b0;
      if (!stall_sat) stall_d = stall_q + 1'b1;
    end else begin
      instr_d   = bus.instruction;
      next_pc_d = pc_plus;
      hit_d     = 1'b1;
      pc_d      = pc_plus;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      next_pc_q <= '0;
      hit_q     <= 1'b0;
      stall_q   <= '0;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      next_pc_q <= next_pc_d;
      hit_q     <= hit_d;
      stall_q   <= stall_d;
    end
  end

  // A flush outranks the hazard, so no bubble is requested on a taken branch.
  assign bus.id_bubble          = hazard & ~bus.branch_taken;
  assign bus.pc                 = pc_q;
  assign bus.instruction_output = instr_q;
  assign bus.nextPC_output      = next_pc_q;
  assign bus.hit_output         = hit_q;
  assign bus.stall_count        = stall_q;

endmodule
